// File: rtl/complex_div_pkg.sv
// Shared types, default widths and saturation limits for the complex divider.
// COMPLEX_DIV_ROUND_EN adds one guard iteration for round-half-away-from-zero.
package complex_div_pkg;

  // IDLE wait | MULT products | PREP num/den/dividend | DIV bit-serial | DONE hold result
  typedef enum logic [2:0] {IDLE, MULT, PREP, DIV, DONE} state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_QWIDTH = 16;
  localparam int DEF_FRAC   = 8;

  localparam int PW = 2 * DEF_WIDTH;
  localparam int NW = PW + 1;
  localparam int DW = NW + DEF_FRAC;

`ifdef COMPLEX_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  function automatic longint sat_pos(input int qw);
    return (64'sd1 <<< (qw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_neg(input int qw);
    return -(64'sd1 <<< (qw - 1));
  endfunction

endpackage

// File: rtl/complex_divider_step.sv
// One restoring-division step: subtract the aligned divisor when it fits.
module serial_udiv_step
  import complex_div_pkg::*;
#(
  parameter int XW = 48
) (
  input  logic [XW-1:0] i_rem,
  input  logic [XW-1:0] i_dvs,
  output logic [XW-1:0] o_rem,
  output logic          o_bit
);

  assign o_bit = (i_rem >= i_dvs);
  assign o_rem = o_bit ? (i_rem - i_dvs) : i_rem;

endmodule

// File: rtl/complex_divider.sv
// Iterative complex divide q = a*conj(b) / |b|^2 with two lockstep restoring dividers.
// COMPLEX_DIV_ROUND_EN: guard bit + round half away from zero (one extra cycle).
module complex_divider
  import complex_div_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int QWIDTH = DEF_QWIDTH,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [WIDTH-1:0]  i_ar,
  input  logic signed [WIDTH-1:0]  i_ai,
  input  logic signed [WIDTH-1:0]  i_br,
  input  logic signed [WIDTH-1:0]  i_bi,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [QWIDTH-1:0] o_qr,
  output logic signed [QWIDTH-1:0] o_qi,
  output logic                     o_ovf,
  output logic                     o_div_by_zero
);

  localparam int MW   = 2 * WIDTH;
  localparam int NWL  = MW + 1;
  localparam int XW   = MW + QWIDTH;
  localparam int ITER = QWIDTH - 1 + RND;
  localparam int CW   = $clog2(QWIDTH + 1);
  localparam logic signed [QWIDTH-1:0] Q_MAX = QWIDTH'(sat_pos(QWIDTH));
  localparam logic signed [QWIDTH-1:0] Q_MIN = QWIDTH'(sat_neg(QWIDTH));

  state_t r_state, w_state_nxt;

  logic signed [WIDTH-1:0]  r_ar, r_ai, r_br, r_bi;
  logic signed [MW-1:0]     r_p_rr, r_p_ii, r_p_ir, r_p_ri;
  logic [MW-1:0]            r_den;
  logic [XW-1:0]            r_rem_r, r_rem_i, r_dvs, w_rem_r, w_rem_i;
  logic                     w_bit_r, w_bit_i;
  logic [QWIDTH-1:0]        r_q_r, r_q_i;
  logic                     r_neg_r, r_neg_i, r_sat_r, r_sat_i, r_exact_r, r_exact_i;
  logic                     r_dbz, r_div0, r_out_valid, r_ovf;
  logic [CW-1:0]            r_cnt;
  logic signed [QWIDTH-1:0] r_qr, r_qi;

  logic signed [NWL-1:0]    w_nr, w_ni;
  logic [NWL-1:0]           w_abs_r, w_abs_i;
  logic [XW-1:0]            w_dext_r, w_dext_i, w_den_top;
  logic                     w_dbz;
  logic [QWIDTH:0]          w_res_r, w_res_i;

  // {ovf, value}; a negative result of exactly the minimum is representable, so not flagged
  function automatic logic [QWIDTH:0] f_result(input logic [QWIDTH-1:0] q,
                                               input logic neg, input logic sat,
                                               input logic exact);
    logic [QWIDTH:0] mag;
    mag = {1'b0, q} >> RND;
    if (RND != 0) mag = mag + (QWIDTH+1)'(q[0]);
    if (sat) return {!(neg && exact), (neg ? Q_MIN : Q_MAX)};
    if (neg) return {1'b0, QWIDTH'(-mag)};
    if (mag[QWIDTH:QWIDTH-1] != 2'b00) return {1'b1, Q_MAX};
    return {1'b0, mag[QWIDTH-1:0]};
  endfunction

  always_comb begin
    w_nr      = NWL'(r_p_rr) + NWL'(r_p_ii);
    w_ni      = NWL'(r_p_ir) - NWL'(r_p_ri);
    w_abs_r   = w_nr[NWL-1] ? $unsigned(-w_nr) : $unsigned(w_nr);
    w_abs_i   = w_ni[NWL-1] ? $unsigned(-w_ni) : $unsigned(w_ni);
    w_dext_r  = XW'(w_abs_r) << (FRAC + RND);
    w_dext_i  = XW'(w_abs_i) << (FRAC + RND);
    w_den_top = XW'(r_den) << ITER;
    w_dbz     = (r_den == '0);
    w_res_r   = f_result(r_q_r, r_neg_r, r_sat_r, r_exact_r);
    w_res_i   = f_result(r_q_i, r_neg_i, r_sat_i, r_exact_i);
  end

  serial_udiv_step #(.XW(XW)) u_step_re (
    .i_rem(r_rem_r), .i_dvs(r_dvs), .o_rem(w_rem_r), .o_bit(w_bit_r)
  );
  serial_udiv_step #(.XW(XW)) u_step_im (
    .i_rem(r_rem_i), .i_dvs(r_dvs), .o_rem(w_rem_i), .o_bit(w_bit_i)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = MULT;
      end
      MULT: w_state_nxt = PREP;
      PREP: w_state_nxt = w_dbz ? DONE : DIV;
      DIV:  if (r_cnt == '0) w_state_nxt = DONE;
      DONE: if (r_out_valid && i_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_p_rr      <= '0;
      r_p_ii      <= '0;
      r_p_ir      <= '0;
      r_p_ri      <= '0;
      r_den       <= '0;
      r_rem_r     <= '0;
      r_rem_i     <= '0;
      r_dvs       <= '0;
      r_q_r       <= '0;
      r_q_i       <= '0;
      r_neg_r     <= 1'b0;
      r_neg_i     <= 1'b0;
      r_sat_r     <= 1'b0;
      r_sat_i     <= 1'b0;
      r_exact_r   <= 1'b0;
      r_exact_i   <= 1'b0;
      r_dbz       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_qr        <= '0;
      r_qi        <= '0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (i_in_valid) begin
          r_ar <= i_ar;
          r_ai <= i_ai;
          r_br <= i_br;
          r_bi <= i_bi;
        end
        MULT: begin
          r_p_rr <= MW'(r_ar) * MW'(r_br);
          r_p_ii <= MW'(r_ai) * MW'(r_bi);
          r_p_ir <= MW'(r_ai) * MW'(r_br);
          r_p_ri <= MW'(r_ar) * MW'(r_bi);
          r_den  <= $unsigned(MW'(r_br) * MW'(r_br)) + $unsigned(MW'(r_bi) * MW'(r_bi));
        end
        PREP: begin
          r_rem_r   <= w_dext_r;
          r_rem_i   <= w_dext_i;
          r_dvs     <= XW'(r_den) << (ITER - 1);
          r_neg_r   <= w_nr[NWL-1];
          r_neg_i   <= w_ni[NWL-1];
          r_sat_r   <= (w_dext_r >= w_den_top);
          r_sat_i   <= (w_dext_i >= w_den_top);
          r_exact_r <= (w_dext_r < (w_den_top + XW'(r_den)));
          r_exact_i <= (w_dext_i < (w_den_top + XW'(r_den)));
          r_dbz     <= w_dbz;
          r_cnt     <= CW'(ITER - 1);
          r_q_r     <= '0;
          r_q_i     <= '0;
        end
        DIV: begin
          r_rem_r <= w_rem_r;
          r_rem_i <= w_rem_i;
          r_q_r   <= {r_q_r[QWIDTH-2:0], w_bit_r};
          r_q_i   <= {r_q_i[QWIDTH-2:0], w_bit_i};
          r_dvs   <= r_dvs >> 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_dbz) begin
              r_qr   <= Q_MAX;
              r_qi   <= Q_MAX;
              r_ovf  <= 1'b1;
              r_div0 <= 1'b1;
            end else begin
              r_qr   <= w_res_r[QWIDTH-1:0];
              r_qi   <= w_res_i[QWIDTH-1:0];
              r_ovf  <= w_res_r[QWIDTH] | w_res_i[QWIDTH];
              r_div0 <= 1'b0;
            end
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_qr          = r_qr;
  assign o_qi          = r_qi;
  assign o_ovf         = r_ovf;
  assign o_div_by_zero = r_div0;

endmodule

// File: tb/tb_complex_divider.sv
// Randomized and directed bench for complex_divider against an integer reference model.
module tb_complex_divider;

  localparam int QW = 16;
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam longint QMAX = 32767;
  localparam longint QMIN = -32768;

  logic clk = 1'b0;
  logic i_rst, i_in_valid, i_out_ready;
  logic o_in_ready, o_out_valid, o_ovf, o_div_by_zero;
  logic signed [15:0] i_ar, i_ai, i_br, i_bi;
  logic signed [15:0] o_qr, o_qi;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  complex_divider dut (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_qr(o_qr), .o_qi(o_qi), .o_ovf(o_ovf), .o_div_by_zero(o_div_by_zero)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint scaled(input longint n, input longint den);
    longint m;
    m = (n < 0) ? -n : n;
    if (RND != 0) m = (m * 512 + den) / (2 * den);
    else          m = (m * 256) / den;
    return (n < 0) ? -m : m;
  endfunction

  task automatic model(input int ar, input int ai, input int br, input int bi,
                       output longint qr, output longint qi, output bit ovf,
                       output bit dbz, output int lat);
    longint nr, ni, den, a_r, a_i, b_r, b_i;
    a_r = ar; a_i = ai; b_r = br; b_i = bi;
    nr  = a_r * b_r + a_i * b_i;
    ni  = a_i * b_r - a_r * b_i;
    den = b_r * b_r + b_i * b_i;
    ovf = 1'b0;
    if (den == 0) begin
      qr = QMAX; qi = QMAX; ovf = 1'b1; dbz = 1'b1; lat = 3;
      return;
    end
    dbz = 1'b0;
    lat = QW + 2 + RND;
    qr  = scaled(nr, den);
    qi  = scaled(ni, den);
    if (qr > QMAX) begin qr = QMAX; ovf = 1'b1; end
    if (qr < QMIN) begin qr = QMIN; ovf = 1'b1; end
    if (qi > QMAX) begin qi = QMAX; ovf = 1'b1; end
    if (qi < QMIN) begin qi = QMIN; ovf = 1'b1; end
  endtask

  task automatic start_op(input int ar, input int ai, input int br, input int bi);
    @(negedge clk);
    check("in_ready_before_accept", o_in_ready, 1);
    i_in_valid = 1'b1;
    i_ar = 16'(ar); i_ai = 16'(ai); i_br = 16'(br); i_bi = 16'(bi);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int ar, input int ai,
                              input int br, input int bi, input int lat);
    longint eqr, eqi; bit eovf, edbz; int elat;
    model(ar, ai, br, bi, eqr, eqi, eovf, edbz, elat);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_qr"}, longint'(o_qr), eqr);
    check({tag, "_qi"}, longint'(o_qi), eqi);
    check({tag, "_ovf"}, o_ovf, eovf);
    check({tag, "_dbz"}, o_div_by_zero, edbz);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    check({tag, "_valid_drop"}, o_out_valid, 0);
    check({tag, "_ready_back"}, o_in_ready, 1);
  endtask

  task automatic run_op(input string tag, input int ar, input int ai, input int br, input int bi);
    int lat;
    start_op(ar, ai, br, bi);
    wait_valid(lat);
    check_result(tag, ar, ai, br, bi, lat);
    take(tag);
  endtask

  function automatic int rs(input int lo, input int hi);
    return int'($urandom_range(hi - lo)) + lo;
  endfunction

  initial begin
    int lat, mode, ar, ai, br, bi;
    longint eqr, eqi; bit eovf, edbz; int elat;
    bit seen;

    i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_ar = '0; i_ai = '0; i_br = '0; i_bi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); i_rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", o_in_ready, 1);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_qr", longint'(o_qr), 0);
    check("rst_qi", longint'(o_qi), 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_dbz", o_div_by_zero, 0);

    run_op("d_2p2j_1p1j", 2, 2, 1, 1);
    run_op("d_1_j", 1, 0, 0, 1);
    run_op("d_m3p4j_1p2j", -3, 4, 1, 2);
    run_op("d_sat_pos", 30000, 0, 1, 0);
    run_op("d_sat_neg", -30000, 0, 1, 0);
    run_op("d_div0", 5, 5, 0, 0);
    run_op("d_zero_zero", 0, 0, 0, 0);
    run_op("d_2_3", 2, 0, 3, 0);
    run_op("d_zero_num", 0, 0, 7, -3);
    run_op("d_exact_min", -128, 0, 1, 0);
    run_op("d_min_ops", -32768, -32768, -32768, -32768);

    // result held under back-pressure while new requests are ignored
    start_op(-3, 4, 1, 2);
    wait_valid(lat);
    check_result("bp", -3, 4, 1, 2, lat);
    model(-3, 4, 1, 2, eqr, eqi, eovf, edbz, elat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_in_valid = 1'b1; i_ar = 16'sd100; i_ai = 16'sd0; i_br = 16'sd1; i_bi = 16'sd0;
      @(posedge clk); #1;
      check("bp_valid", o_out_valid, 1);
      check("bp_in_ready", o_in_ready, 0);
      check("bp_qr", longint'(o_qr), eqr);
      check("bp_qi", longint'(o_qi), eqi);
    end
    i_in_valid = 1'b0;
    take("bp");
    run_op("after_bp", 9, -4, 2, 1);

    // reset mid-division drops the operation
    start_op(1000, 2000, 3, 4);
    repeat (6) @(posedge clk);
    @(negedge clk); i_rst = 1'b1;
    @(posedge clk); #1; i_rst = 1'b0;
    check("rst_div_in_ready", o_in_ready, 1);
    check("rst_div_valid", o_out_valid, 0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_out_valid) seen = 1'b1;
    end
    check("rst_div_no_output", seen, 0);
    run_op("after_rst", 2, 0, 3, 0);

    for (int t = 0; t < 40; t++) begin
      mode = rs(0, 3);
      case (mode)
        0: begin ar = rs(-32768, 32767); ai = rs(-32768, 32767); br = rs(-32768, 32767); bi = rs(-32768, 32767); end
        1: begin ar = rs(-100, 100); ai = rs(-100, 100); br = rs(-32768, 32767); bi = rs(-32768, 32767); end
        2: begin ar = rs(-2000, 2000); ai = rs(-2000, 2000); br = rs(-8, 8); bi = rs(-8, 8); end
        default: begin ar = rs(-50, 50); ai = rs(-50, 50); br = rs(-50, 50); bi = rs(-50, 50); end
      endcase
      run_op($sformatf("rnd%0d", t), ar, ai, br, bi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
